uart_instr_rx: RTL and testbench
================================

UART_INSTR_RX -- requirements
Module: uart_instr_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5208, meaning clk cycles per UART bit (>=4).
REQ-002 SHALL have parameter PARITY, default 1, meaning 0=none, 1=even, 2=odd.
REQ-003 SHALL have parameter WORD_BYTES, default 4, meaning bytes per instruction word; W=8*WORD_BYTES.
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, meaning word FIFO entries (power of 2, >=2).
REQ-005 SHALL have parameter TIMEOUT_BITS, default 32, meaning idle bit-times before a partial word is discarded.
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-008 SHALL have port uart_rx, input, 1, meaning async serial line, idle high.
REQ-009 SHALL have port fetch_enable, input, 1, meaning fetch request.
REQ-010 SHALL have port instr_addr, input, 3, meaning fetch address.
REQ-011 SHALL have port instr, output, W, meaning registered fetched instruction.
REQ-012 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, meaning stored word count.
REQ-013 SHALL have port err_clear, input, 1, meaning clears sticky flags.
REQ-014 SHALL have ports parity_err, frame_err, overflow, output, 1 each, meaning sticky error flags.

Function
REQ-015 SHALL pass uart_rx through a 2-flop synchronizer (flops reset to 1) before any use.
REQ-016 SHALL implement FSM IDLE->START->DATA->PARITY->STOP->IDLE; PARITY skipped when PARITY=0.
REQ-017 SHALL leave IDLE on synced-low with bit counter cleared; START samples at CLK_DIV/2; high there -> IDLE (glitch, no error).
REQ-018 SHALL sample DATA, PARITY, STOP every CLK_DIV clocks after the START sample, 8 data bits LSB first.
REQ-019 SHALL, on parity mismatch, set parity_err, discard byte and partial word, byte index -> 0.
REQ-020 SHALL, on stop bit low, set frame_err, discard partial word, and re-arm IDLE only after line seen high.
REQ-021 SHALL place accepted byte k (k=0 first) at instr bits [W-1-8k -: 8] (first byte most significant).
REQ-022 SHALL push the word on the last byte's stop sample; if FIFO full and no same-cycle pop, drop word and set overflow.
REQ-023 SHALL discard a partial word (byte index !=0) after TIMEOUT_BITS*CLK_DIV consecutive IDLE clocks; no flag.
REQ-024 SHALL, on instr_addr=0 with fetch_enable and FIFO non-empty, load head word into instr next edge and pop.
REQ-025 SHALL load instr with JAL_SELF (32'hfa9ef06f, zero-extended to W) when instr_addr=4, regardless of fetch_enable.
REQ-026 SHALL load instr with NOP (32'h00000013, zero-extended) in all other cases, including addr 0 with FIFO empty.
REQ-027 SHALL let simultaneous push and pop both succeed, level unchanged, including when full.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH; fifo_level exact 0..FIFO_DEPTH.
REQ-029 SHALL clear sticky flags on err_clear; a same-cycle set wins over clear.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force FSM IDLE, counters/byte index 0, FIFO empty, flags 0, instr=NOP.
REQ-031 SHALL discard any in-flight frame or partial word on reset; first post-reset frame starts cleanly.

Structure
REQ-032 SHALL place parity-mode constants, FSM state encoding, NOP and JAL_SELF constants in package uart_rx_pkg.
REQ-033 SHALL instantiate one sub-module uart_rx_fifo (sync FIFO, show-ahead head word, level output).

Verification
REQ-034 SHALL verify CLK_DIV=16, even parity: bytes 0x12,0x34,0x56,0x78 -> fifo_level 1; addr 0 fetch -> instr=0x12345678, level 0.
REQ-035 SHALL verify 4-clock low pulse on idle line -> no byte, no flags, FSM IDLE.
REQ-036 SHALL verify second byte with flipped parity -> parity_err=1, next 4 valid bytes form a word.
REQ-037 SHALL verify FIFO_DEPTH=2: push 3 words, no fetch -> overflow=1, level 2, fetches return words 1,2, then NOP.
REQ-038 SHALL verify 2 bytes then idle TIMEOUT_BITS*16 clocks -> partial dropped; next 4 bytes form one word.
REQ-039 SHALL verify rst_n low mid-byte and addr 4 fetch -> instr=NOP during reset, 0xfa9ef06f after one edge.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants and FSM encoding for the UART instruction receiver.
package uart_rx_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] JAL_SELF  = 32'hfa9e_f06f;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous word FIFO with show-ahead head word and exact fill level.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_instr_rx.sv
// UART receiver that assembles bytes into instruction words, queues them,
// and serves them through a registered fetch port with NOP/JAL_SELF fallbacks.
module uart_instr_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 5208,
    parameter int unsigned PARITY       = 1,
    parameter int unsigned WORD_BYTES   = 4,
    parameter int unsigned FIFO_DEPTH   = 64,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx,
    input  logic                          fetch_enable,
    input  logic [2:0]                    instr_addr,
    output logic [8*WORD_BYTES-1:0]       instr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          err_clear,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int unsigned W       = 8 * WORD_BYTES;
    localparam int unsigned CNT_W   = $clog2(CLK_DIV);
    localparam int unsigned TO_CLKS = TIMEOUT_BITS * CLK_DIV;
    localparam int unsigned TO_W    = $clog2(TO_CLKS + 1);
    localparam int unsigned BI_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [CNT_W-1:0] HALF_M1    = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1    = CNT_W'(CLK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_M1      = TO_W'(TO_CLKS - 1);
    localparam logic [BI_W-1:0]  LAST_BYTE  = BI_W'(WORD_BYTES - 1);
    localparam logic             HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic             ODD_PAR    = !(PARITY == PARITY_EVEN);

    logic [1:0]       sync_q, sync_d;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_acc_q, par_acc_d;
    logic             par_bad_q, par_bad_d;
    logic             wait_high_q, wait_high_d;
    logic [BI_W-1:0]  byte_idx_q, byte_idx_d;
    logic [W-1:0]     word_q, word_d;
    logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [W-1:0]     instr_q, instr_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;

    logic             rx_s;
    logic             bit_tick;
    logic             word_push;
    logic             par_set, frame_set, ovf_set;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [W-1:0]     fifo_head;

    assign rx_s     = sync_q[1];
    assign bit_tick = (cnt_q == FULL_M1);

    uart_rx_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (word_push),
        .push_data (word_d),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        sync_d      = {sync_q[0], uart_rx};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        par_acc_d   = par_acc_q;
        par_bad_d   = par_bad_q;
        wait_high_d = wait_high_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        idle_cnt_d  = '0;
        word_push   = 1'b0;
        par_set     = 1'b0;
        frame_set   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (idle_cnt_q == TO_M1) begin
                    idle_cnt_d = idle_cnt_q;
                    byte_idx_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                // After a framing error the line must be seen high before a new start.
                if (rx_s) begin
                    wait_high_d = 1'b0;
                end else if (!wait_high_q) begin
                    state_d   = ST_START;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    par_acc_d = 1'b0;
                    par_bad_d = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    par_acc_d = par_acc_q ^ rx_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                    if ((par_acc_q ^ rx_s) != ODD_PAR) begin
                        par_bad_d  = 1'b1;
                        par_set    = 1'b1;
                        byte_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!rx_s) begin
                        frame_set   = 1'b1;
                        byte_idx_d  = '0;
                        wait_high_d = 1'b1;
                    end else if (!par_bad_q) begin
                        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
                            if (byte_idx_q == BI_W'(k)) begin
                                word_d[W-1-8*k -: 8] = shreg_q;
                            end
                        end
                        if (byte_idx_q == LAST_BYTE) begin
                            word_push  = 1'b1;
                            byte_idx_d = '0;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = fetch_enable && (instr_addr == 3'd0) && !fifo_empty;
        if (instr_addr == 3'd4) begin
            instr_d = W'(JAL_SELF);
        end else if (fifo_pop) begin
            instr_d = fifo_head;
        end else begin
            instr_d = W'(NOP_INSTR);
        end
        ovf_set      = word_push && fifo_full && !fifo_pop;
        parity_err_d = par_set   | (parity_err_q & ~err_clear);
        frame_err_d  = frame_set | (frame_err_q  & ~err_clear);
        overflow_d   = ovf_set   | (overflow_q   & ~err_clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_acc_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            wait_high_q  <= 1'b0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            idle_cnt_q   <= '0;
            instr_q      <= W'(NOP_INSTR);
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_acc_q    <= par_acc_d;
            par_bad_q    <= par_bad_d;
            wait_high_q  <= wait_high_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            idle_cnt_q   <= idle_cnt_d;
            instr_q      <= instr_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign instr      = instr_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_instr_rx.sv
// Randomized scoreboard bench for uart_instr_rx against a queue-based frame/word model.
module tb_uart_instr_rx;

    localparam int unsigned CLK_DIV      = 16;
    localparam int unsigned PARITY       = 1;
    localparam int unsigned WORD_BYTES   = 4;
    localparam int unsigned FIFO_DEPTH   = 2;
    localparam int unsigned TIMEOUT_BITS = 8;
    localparam int unsigned W            = 8 * WORD_BYTES;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] JAL          = 32'hfa9e_f06f;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          uart_rx = 1'b1;
    logic                          fetch_enable = 1'b0;
    logic [2:0]                    instr_addr = 3'd1;
    logic                          err_clear = 1'b0;
    logic [W-1:0]                  instr;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          parity_err, frame_err, overflow;

    uart_instr_rx #(
        .CLK_DIV      (CLK_DIV),
        .PARITY       (PARITY),
        .WORD_BYTES   (WORD_BYTES),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .fetch_enable (fetch_enable),
        .instr_addr   (instr_addr),
        .instr        (instr),
        .fifo_level   (fifo_level),
        .err_clear    (err_clear),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_fifo[$];
    logic [7:0]   m_part[$];
    bit           m_par = 1'b0, m_frame = 1'b0, m_ovf = 1'b0;
    bit           fetch_strobe = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_level"}, 64'(fifo_level), 64'(m_fifo.size()));
        check({tag, "_parity_err"}, 64'(parity_err), 64'(m_par));
        check({tag, "_frame_err"}, 64'(frame_err), 64'(m_frame));
        check({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
    endtask

    // Reference: a byte either joins the partial word or kills it; full words queue up.
    task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [W-1:0] w;
        if (bad_par) begin
            m_par = 1'b1;
            m_part.delete();
        end
        if (bad_stop) begin
            m_frame = 1'b1;
            m_part.delete();
        end else if (!bad_par) begin
            m_part.push_back(b);
            if (m_part.size() == WORD_BYTES) begin
                w = '0;
                foreach (m_part[i]) w = (w << 8) | W'(m_part[i]);
                m_part.delete();
                if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(w);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((^b) ^ bad_par);
        send_bit(!bad_stop);
        uart_rx = 1'b1;
        model_byte(b, bad_par, bad_stop);
        check_state("byte");
    endtask

    task automatic do_fetch(input logic [2:0] addr, input logic en);
        logic [W-1:0] e;
        instr_addr   = addr;
        fetch_enable = en;
        fetch_strobe = 1'b1;
        if (addr == 3'd4) e = W'(JAL);
        else if (addr == 3'd0 && en && m_fifo.size() > 0) e = m_fifo.pop_front();
        else e = W'(NOP);
        exp_q.push_back(e);
        @(negedge clk);
        instr_addr   = 3'd1;
        fetch_enable = 1'b0;
        fetch_strobe = 1'b0;
        check("fetch_level", 64'(fifo_level), 64'(m_fifo.size()));
    endtask

    task automatic gap(input int unsigned n, input bit allow_fetch);
        logic [2:0] a;
        int unsigned r;
        uart_rx = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            if (allow_fetch && $urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 7);
                a = (r < 5) ? 3'd0 : ((r == 5) ? 3'd4 : 3'(r));
                do_fetch(a, $urandom_range(0, 3) != 0);
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic clear_flags();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        m_par = 1'b0;
        m_frame = 1'b0;
        m_ovf = 1'b0;
        check_state("clear");
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8], 1'b0, 1'b0);
            gap(20, 1'b0);
        end
    endtask

    // Monitor: every strobed fetch edge must load the next expected word.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && fetch_strobe) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow actual=%0h expected=none", instr);
                end else begin
                    check("instr", 64'(instr), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_instr", 64'(instr), 64'(NOP));
        check_state("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic word and fetch.
        send_word(32'h1234_5678);
        check("lvl_one", 64'(fifo_level), 64'd1);
        do_fetch(3'd0, 1'b1);
        check("lvl_zero", 64'(fifo_level), 64'd0);
        do_fetch(3'd0, 1'b1);

        // Short low glitch on idle line.
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        gap(40, 1'b0);
        check_state("glitch");

        // Parity error in second byte discards the partial word.
        send_byte(8'hA5, 1'b0, 1'b0); gap(20, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0); gap(20, 1'b0);
        check("par_flag", 64'(parity_err), 64'd1);
        send_word(32'hDEAD_BEEF);
        do_fetch(3'd0, 1'b1);
        clear_flags();

        // Framing error then recovery.
        send_byte(8'h11, 1'b0, 1'b0); gap(20, 1'b0);
        send_byte(8'h22, 1'b0, 1'b1); gap(20, 1'b0);
        check("frame_flag", 64'(frame_err), 64'd1);
        send_word(32'hCAFE_F00D);
        do_fetch(3'd0, 1'b1);
        clear_flags();

        // Overflow with a 2-entry FIFO.
        send_word(32'h0102_0304);
        send_word(32'h0506_0708);
        send_word(32'h090A_0B0C);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_level", 64'(fifo_level), 64'd2);
        do_fetch(3'd0, 1'b1);
        do_fetch(3'd0, 1'b1);
        do_fetch(3'd0, 1'b1);
        do_fetch(3'd4, 1'b0);
        do_fetch(3'd3, 1'b1);
        clear_flags();

        // Partial word timeout.
        send_byte(8'h77, 1'b0, 1'b0); gap(20, 1'b0);
        send_byte(8'h88, 1'b0, 1'b0);
        gap(TIMEOUT_BITS * CLK_DIV + 32, 1'b0);
        m_part.delete();
        send_word(32'h4455_6677);
        check("timeout_level", 64'(fifo_level), 64'd1);
        do_fetch(3'd0, 1'b0);
        do_fetch(3'd0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 11) == 0,
                      $urandom_range(0, 13) == 0);
            if ($urandom_range(0, 9) == 0) clear_flags();
            gap($urandom_range(16, 40), 1'b1);
        end

        // Reset in the middle of a byte with two bytes already pending.
        send_byte(8'h5A, 1'b0, 1'b0); gap(20, 1'b0);
        send_byte(8'h6B, 1'b0, 1'b0); gap(20, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        uart_rx = 1'b0;
        repeat (CLK_DIV / 2) @(negedge clk);
        instr_addr = 3'd4;
        @(negedge clk);
        check("pre_reset_jal", 64'(instr), 64'(JAL));
        rst_n = 1'b0;
        uart_rx = 1'b1;
        #1;
        check("reset_async_instr", 64'(instr), 64'(NOP));
        m_fifo.delete();
        m_part.delete();
        m_par = 1'b0;
        m_frame = 1'b0;
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hold_instr", 64'(instr), 64'(NOP));
        check_state("reset_mid");
        exp_q.push_back(W'(JAL));
        fetch_strobe = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        fetch_strobe = 1'b0;
        instr_addr = 3'd1;
        gap(20, 1'b0);
        send_word(32'h8765_4321);
        check("post_reset_level", 64'(fifo_level), 64'd1);

        // Drain.
        while (m_fifo.size() > 0) do_fetch(3'd0, 1'b1);
        do_fetch(3'd0, 1'b1);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
